// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
//
// Turns short, clock-synchronous event requests into LED pulses long enough
// to be seen. Each rising edge on event_in yields exactly one led_out pulse
// of ON_TIME clocks followed by at least OFF_TIME dark clocks. Events that
// arrive while a pulse is running are queued in a saturating counter, so
// bursts are replayed as a continuous ON/OFF train rather than merged.
//
// Parameters
//   ON_TIME   clocks led_out is held high per event (>= 1)
//   OFF_TIME  minimum clocks led_out is held low after each pulse (>= 1)
//   PEND_MAX  maximum number of queued events (>= 1)
//
// Ports
//   clk         clock
//   rst         asynchronous, active-high reset; clears all state
//   event_in    event request, synchronous to clk; each 0->1 is one event
//   led_out     stretched pulse (registered)
//   busy        high whenever the controller is not idle
//   pend_count  events queued and not yet started
//   overflow    sticky flag: an event was dropped at saturation
module led_pulse_stretcher #(
    parameter int ON_TIME  = 20_000_000,
    parameter int OFF_TIME = 20_000_000,
    parameter int PEND_MAX = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          event_in,
    output logic                          led_out,
    output logic                          busy,
    output logic [$clog2(PEND_MAX+1)-1:0] pend_count,
    output logic                          overflow
);

    localparam int MAX_T  = (ON_TIME > OFF_TIME) ? ON_TIME : OFF_TIME;
    // A one-clock maximum would give a zero-width counter; keep at least 1 bit.
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int PEND_W = $clog2(PEND_MAX + 1);

    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_TIME - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_TIME - 1);
    localparam logic [PEND_W-1:0] PEND_LIM = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              ovf_reg, ovf_next;
    logic              event_d_reg;
    logic              led_reg;

    logic edge_det;
    logic last_cycle;
    logic ready;

    always_comb begin
        edge_det   = event_in & ~event_d_reg;
        last_cycle = (cnt_reg == '0);
        // Any state other than ON/OFF (including the unused encoding) is
        // treated as idle, so a corrupted state recovers on the next clock.
        ready      = ((state_reg != ST_ON) && (state_reg != ST_OFF)) ||
                     ((state_reg == ST_OFF) && last_cycle);

        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        ovf_next   = ovf_reg;

        if (ready) begin
            if (pend_reg != '0) begin
                // Start a queued event; a simultaneous edge takes the slot
                // just freed, so the count nets to unchanged.
                state_next = ST_ON;
                cnt_next   = ON_LOAD;
                if (!edge_det) begin
                    pend_next = pend_reg - PEND_ONE;
                end
            end else if (edge_det) begin
                state_next = ST_ON;
                cnt_next   = ON_LOAD;
            end else begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        end else begin
            if ((state_reg == ST_ON) && last_cycle) begin
                state_next = ST_OFF;
                cnt_next   = OFF_LOAD;
            end else begin
                cnt_next = cnt_reg - CNT_W'(1);
            end

            if (edge_det) begin
                if (pend_reg < PEND_LIM) begin
                    pend_next = pend_reg + PEND_ONE;
                end else begin
                    ovf_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            pend_reg    <= '0;
            ovf_reg     <= 1'b0;
            // Reset high so an input already asserted at release is ignored.
            event_d_reg <= 1'b1;
            led_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pend_reg    <= pend_next;
            ovf_reg     <= ovf_next;
            event_d_reg <= event_in;
            led_reg     <= (state_next == ST_ON);
        end
    end

    assign led_out    = led_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign pend_count = pend_reg;
    assign overflow   = ovf_reg;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed testbench for led_pulse_stretcher with ON_TIME=4, OFF_TIME=3,
// PEND_MAX=2. Cycle i of a window is the interval after the i-th rising
// clock edge of that window; event_in is driven for that interval and the
// outputs are sampled on the falling edge inside it.
module tb_led_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       event_in = 1'b0;
    logic       led_out;
    logic       busy;
    logic [1:0] pend_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [63:0] led_v;
    logic [63:0] busy_v;
    logic [63:0] ovf_v;
    int          pend_a [64];

    led_pulse_stretcher #(
        .ON_TIME (4),
        .OFF_TIME(3),
        .PEND_MAX(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .event_in  (event_in),
        .led_out   (led_out),
        .busy      (busy),
        .pend_count(pend_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] m(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Drive ev[i] during cycle i for n cycles and log outputs.
    // Entered and left just after a rising clock edge.
    task automatic run(input logic [63:0] ev, input int n);
        led_v  = '0;
        busy_v = '0;
        ovf_v  = '0;
        for (int i = 0; i < 64; i++) pend_a[i] = 0;
        for (int i = 0; i < n; i++) begin
            event_in = ev[i];
            @(negedge clk);
            led_v[i]  = led_out;
            busy_v[i] = busy;
            ovf_v[i]  = overflow;
            pend_a[i] = int'(pend_count);
            @(posedge clk);
            #1;
        end
    endtask

    // Reset with event_in low, plus one settling cycle so the next window
    // can open with an edge in cycle 0.
    task automatic reset_idle();
        event_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int pend_or;
        event_in = 1'b1;
        #2 rst = 1'b1;
        #3;
        checks++; if (led_out !== 1'b0)    begin errors++; $display("FAIL reset_led got %b want 0", led_out); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (pend_count !== 2'd0) begin errors++; $display("FAIL reset_pend got %0d want 0", pend_count); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // Input held high across release: no event.
        run(64'hF_FFFF, 20);
        checks++; if (led_v !== 64'd0)  begin errors++; $display("FAIL held_high_led got %h want 0", led_v); end
        checks++; if (busy_v !== 64'd0) begin errors++; $display("FAIL held_high_busy got %h want 0", busy_v); end
        pend_or = 0;
        for (int i = 0; i < 20; i++) pend_or |= pend_a[i];
        checks++; if (pend_or !== 0) begin errors++; $display("FAIL held_high_pend got %0d want 0", pend_or); end
        // Drop, then rise in cycle 1: pulse from cycle 2.
        run(64'h2, 12);
        checks++; if (led_v !== m(2, 5)) begin errors++; $display("FAIL first_edge_led got %h want %h", led_v, m(2, 5)); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int pend_or;
        // Held high for 3 cycles: still one event.
        run(64'h7, 10);
        checks++; if (led_v !== m(1, 4))  begin errors++; $display("FAIL single_led got %h want %h", led_v, m(1, 4)); end
        checks++; if (busy_v !== m(1, 7)) begin errors++; $display("FAIL single_busy got %h want %h", busy_v, m(1, 7)); end
        pend_or = 0;
        for (int i = 0; i < 10; i++) pend_or |= pend_a[i];
        checks++; if (pend_or !== 0) begin errors++; $display("FAIL single_pend got %0d want 0", pend_or); end
        $display("test_single done");
    endtask

    task automatic test_queue();
        logic [63:0] exp_led;
        exp_led = m(1, 4) | m(8, 11) | m(15, 18);
        run(64'h15, 25);
        checks++; if (led_v !== exp_led)    begin errors++; $display("FAIL queue_led got %h want %h", led_v, exp_led); end
        checks++; if (busy_v !== m(1, 21))  begin errors++; $display("FAIL queue_busy got %h want %h", busy_v, m(1, 21)); end
        checks++; if (ovf_v !== 64'd0)      begin errors++; $display("FAIL queue_ovf got %h want 0", ovf_v); end
        checks++; if (pend_a[2] !== 0)      begin errors++; $display("FAIL queue_pend2 got %0d want 0", pend_a[2]); end
        checks++; if (pend_a[3] !== 1)      begin errors++; $display("FAIL queue_pend3 got %0d want 1", pend_a[3]); end
        checks++; if (pend_a[5] !== 2)      begin errors++; $display("FAIL queue_pend5 got %0d want 2", pend_a[5]); end
        checks++; if (pend_a[8] !== 1)      begin errors++; $display("FAIL queue_pend8 got %0d want 1", pend_a[8]); end
        checks++; if (pend_a[15] !== 0)     begin errors++; $display("FAIL queue_pend15 got %0d want 0", pend_a[15]); end
        $display("test_queue done");
    endtask

    task automatic test_overflow();
        logic [63:0] exp_led;
        exp_led = m(1, 4) | m(8, 11) | m(15, 18);
        run(64'h55, 26);
        checks++; if (led_v !== exp_led)    begin errors++; $display("FAIL ovf_led got %h want %h", led_v, exp_led); end
        checks++; if (busy_v !== m(1, 21))  begin errors++; $display("FAIL ovf_busy got %h want %h", busy_v, m(1, 21)); end
        checks++; if (ovf_v !== m(7, 25))   begin errors++; $display("FAIL ovf_flag got %h want %h", ovf_v, m(7, 25)); end
        checks++; if (pend_a[7] !== 2)      begin errors++; $display("FAIL ovf_pend7 got %0d want 2", pend_a[7]); end
        checks++; if (pend_a[8] !== 1)      begin errors++; $display("FAIL ovf_pend8 got %0d want 1", pend_a[8]); end
        $display("test_overflow done");
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_led;
        int pend_or;
        reset_idle();
        // pend_count=1 and an edge on the last OFF cycle (cycle 7).
        exp_led = m(1, 4) | m(8, 11) | m(15, 18);
        run(64'h85, 24);
        checks++; if (led_v !== exp_led)    begin errors++; $display("FAIL b2b_q_led got %h want %h", led_v, exp_led); end
        checks++; if (busy_v !== m(1, 21))  begin errors++; $display("FAIL b2b_q_busy got %h want %h", busy_v, m(1, 21)); end
        checks++; if (pend_a[7] !== 1)      begin errors++; $display("FAIL b2b_q_pend7 got %0d want 1", pend_a[7]); end
        checks++; if (pend_a[8] !== 1)      begin errors++; $display("FAIL b2b_q_pend8 got %0d want 1", pend_a[8]); end
        checks++; if (pend_a[15] !== 0)     begin errors++; $display("FAIL b2b_q_pend15 got %0d want 0", pend_a[15]); end
        // pend_count=0 and an edge on the last OFF cycle.
        exp_led = m(1, 4) | m(8, 11);
        run(64'h81, 18);
        checks++; if (led_v !== exp_led)    begin errors++; $display("FAIL b2b_d_led got %h want %h", led_v, exp_led); end
        checks++; if (busy_v !== m(1, 14))  begin errors++; $display("FAIL b2b_d_busy got %h want %h", busy_v, m(1, 14)); end
        pend_or = 0;
        for (int i = 0; i < 18; i++) pend_or |= pend_a[i];
        checks++; if (pend_or !== 0) begin errors++; $display("FAIL b2b_d_pend got %0d want 0", pend_or); end
        $display("test_back_to_back done");
    endtask

    task automatic test_async_reset();
        reset_idle();
        // Edges at 0,2,4,6,8: overflow at 7, pend back to 2 at 9, pulse 2 in 8..11.
        run(64'h155, 10);
        checks++; if (led_out !== 1'b1)    begin errors++; $display("FAIL pre_rst_led got %b want 1", led_out); end
        checks++; if (pend_count !== 2'd2) begin errors++; $display("FAIL pre_rst_pend got %0d want 2", pend_count); end
        checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL pre_rst_ovf got %b want 1", overflow); end
        #1 rst = 1'b1;
        #1;
        checks++; if (led_out !== 1'b0)    begin errors++; $display("FAIL async_rst_led got %b want 0", led_out); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL async_rst_busy got %b want 0", busy); end
        checks++; if (pend_count !== 2'd0) begin errors++; $display("FAIL async_rst_pend got %0d want 0", pend_count); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL async_rst_ovf got %b want 0", overflow); end
        event_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(64'd0, 20);
        checks++; if (led_v !== 64'd0)  begin errors++; $display("FAIL post_rst_led got %h want 0", led_v); end
        checks++; if (busy_v !== 64'd0) begin errors++; $display("FAIL post_rst_busy got %h want 0", busy_v); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Output-side counterpart to the switch debouncer: converts short, clock-synchronous event requests into LED pulses long enough for a person to see. Each rising edge on `event_in` produces exactly one `led_out` pulse of ON_TIME clocks followed by a guaranteed OFF_TIME dark gap. Events arriving while a pulse is in progress are queued in a saturating pending counter, so none are merged or lost up to PEND_MAX. Sits between wave_gen status/command logic and the board LEDs.

## Interface
- `ON_TIME`, 20_000_000, clocks `led_out` is held high per event; legal range ≥1.
- `OFF_TIME`, 20_000_000, minimum clocks `led_out` is held low after each pulse; legal range ≥1.
- `PEND_MAX`, 7, maximum number of queued events; legal range ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous and active-high; all state clears immediately, with no dependence on `clk`.
- `event_in`  in  1  event request; already synchronous to `clk`. Each 0→1 transition is one event.
- `led_out`  out  1  stretched pulse, registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `pend_count`  out  clogb2(PEND_MAX+1)  number of events queued and not yet started.
- `overflow`  out  1  sticky; set when an event is dropped at saturation. Cleared only by `rst`.

## Operation
- Edge detect: `edge = event_in & ~event_in_d`. `event_in_d` resets to 1, so an input already high when reset releases is not an event.
- States:
  - IDLE: `led_out` = 0.
  - ON: `led_out` = 1.
  - OFF: `led_out` = 0.
- Down-counter width is clogb2(max(ON_TIME, OFF_TIME)).
  - Entering ON loads ON_TIME-1.
  - Entering OFF loads OFF_TIME-1.
  - The counter decrements each clock. Count 0 marks the last cycle of the state.
- Ready point: any IDLE cycle, or the last OFF cycle. At a ready point:
  - If `pend_count` > 0: go to ON; `pend_count` ← `pend_count` − 1 + edge. There is no overflow in this case, since the decrement frees a slot.
  - Else if edge: go to ON; the edge is consumed directly and `pend_count` stays 0.
  - Else: go to (or stay in) IDLE.
- ON, last cycle: go to OFF.
- Edge outside a ready point:
  - If `pend_count` < PEND_MAX: `pend_count` + 1.
  - Else: `pend_count` holds and `overflow` ← 1.
- Back-to-back queued events therefore produce a continuous ON/OFF train with no IDLE cycle between pulses.

## Timing
- Reset values:
  - state IDLE, counter 0, `event_in_d` 1.
  - `led_out` 0, `busy` 0, `pend_count` 0, `overflow` 0.
- Latency: edge sampled in cycle N at a ready point → `led_out` = 1 from cycle N+1.
- Pulse: `led_out` high for exactly ON_TIME cycles, then low for at least OFF_TIME cycles. Period of back-to-back pulses is ON_TIME + OFF_TIME.
- `busy` rises together with `led_out`. It falls on the first IDLE cycle after OFF, i.e. N+ON_TIME+OFF_TIME+1 for a lone event.
- `pend_count` and `overflow` update on the clock edge following the sampled edge.
- `event_in` held high produces one event only. Width of the input pulse beyond one cycle is irrelevant.
- Asynchronous `rst` mid-pulse: `led_out`, `busy`, `pend_count` and `overflow` go to 0 without a clock edge. Queued events are discarded.

## Test plan
Parameters ON_TIME=4, OFF_TIME=3, PEND_MAX=2.
1. Reset with `event_in` held 1, then release → `led_out` stays 0 for 20 cycles and `pend_count` stays 0. Drop `event_in` to 0 and raise it at cycle N → pulse starts at N+1.
2. Single edge at cycle N from IDLE → `led_out` = 1 for N+1..N+4 and 0 for N+5..N+7. `busy` = 1 for N+1..N+7 and 0 at N+8. `pend_count` = 0 throughout.
3. Edges at N, N+2 and N+4 → `pend_count` = 1 at N+3 and 2 at N+5. Pulses start at N+1, N+8 and N+15. `busy` stays continuously high until N+22. `overflow` = 0.
4. Edges at N, N+2, N+3 (rising at N+3 after a low at N+2.5 is not possible; use N, N+2, N+4, N+6) → `pend_count` saturates at 2. `overflow` = 1 from N+7. Exactly 3 pulses are produced.
5. With `pend_count` = 1, an edge on the last OFF cycle → next ON starts at the following cycle and `pend_count` stays 1. With `pend_count` = 0, an edge on the last OFF cycle → ON starts immediately and `pend_count` stays 0.
6. Assert `rst` asynchronously in the middle of cycle N+2 of a pulse with `pend_count` = 2 → `led_out`, `busy`, `pend_count` and `overflow` are 0 before the next `clk` edge. No pulse follows after release.
